// File: rtl/cl2_csr_pkg.sv
// Shared types and helpers for the CSR access sequencer: op/state encodings,
// privilege levels and CSR address-field decode.
package cl2_csr_pkg;
  localparam int XLEN      = 32;
  localparam int ADDR_W    = 12;
  localparam int NUM_PORTS = 2;

  typedef enum logic [1:0] {
    CSR_READ = 2'd0,
    CSR_RW   = 2'd1,
    CSR_RS   = 2'd2,
    CSR_RC   = 2'd3
  } csr_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RESP
  } csr_state_e;

  localparam logic [1:0] PRIV_U = 2'd0;
  localparam logic [1:0] PRIV_S = 2'd1;
  localparam logic [1:0] PRIV_M = 2'd3;

  typedef struct packed {
    logic              id;
    logic [ADDR_W-1:0] addr;
    csr_op_e           op;
    logic [XLEN-1:0]   wdata;
    logic [1:0]        priv;
  } csr_req_t;

  function automatic logic [1:0] csr_ro_bits(input logic [ADDR_W-1:0] addr);
    return addr[11:10];
  endfunction

  function automatic logic [1:0] csr_priv_bits(input logic [ADDR_W-1:0] addr);
    return addr[9:8];
  endfunction

  // RS/RC with a zero mask are pure reads and must not trip read-only faults.
  function automatic logic csr_op_writes(input csr_op_e op, input logic [XLEN-1:0] wdata);
    return (op == CSR_RW) || (((op == CSR_RS) || (op == CSR_RC)) && (wdata != '0));
  endfunction

  function automatic logic csr_illegal(input logic [ADDR_W-1:0] addr, input csr_op_e op,
                                       input logic [XLEN-1:0] wdata, input logic [1:0] priv);
    return (csr_priv_bits(addr) > priv) ||
           ((csr_ro_bits(addr) == 2'b11) && csr_op_writes(op, wdata));
  endfunction
endpackage

// File: rtl/cl2_csr_access_ctrl_if.sv
// Request, field-array and response channels of the CSR access sequencer.
interface cl2_csr_access_ctrl_if;
  import cl2_csr_pkg::*;

  logic [NUM_PORTS-1:0]             req_valid_i;
  logic [NUM_PORTS-1:0]             req_ready_o;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] req_addr_i;
  logic [NUM_PORTS-1:0][1:0]        req_op_i;
  logic [NUM_PORTS-1:0][XLEN-1:0]   req_wdata_i;
  logic [1:0]                       priv_i;

  logic [ADDR_W-1:0] csr_addr_o;
  logic [XLEN-1:0]   csr_rdata_i;
  logic              csr_we_o;
  logic [XLEN-1:0]   csr_wdata_o;

  logic              resp_valid_o;
  logic              resp_ready_i;
  logic              resp_id_o;
  logic [XLEN-1:0]   resp_rdata_o;
  logic              resp_err_o;

  modport slave (
    input  req_valid_i, req_addr_i, req_op_i, req_wdata_i, priv_i, csr_rdata_i, resp_ready_i,
    output req_ready_o, csr_addr_o, csr_we_o, csr_wdata_o,
           resp_valid_o, resp_id_o, resp_rdata_o, resp_err_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_op_i, req_wdata_i, priv_i, csr_rdata_i, resp_ready_i,
    input  req_ready_o, csr_addr_o, csr_we_o, csr_wdata_o,
           resp_valid_o, resp_id_o, resp_rdata_o, resp_err_o
  );
endinterface

// File: rtl/cl2_csr_rr_arb.sv
// Two-requester round-robin arbiter; pointer moves past the served port on adv.
module cl2_csr_rr_arb
  import cl2_csr_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [NUM_PORTS-1:0] req,
  output logic [NUM_PORTS-1:0] gnt,
  input  logic                 adv,
  input  logic                 adv_id
);
  logic ptr;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i)  ptr <= 1'b0;
    else if (adv)  ptr <= ~adv_id;
  end

  // Pointer only matters under contention; a lone requester always wins.
  always_comb begin
    gnt = req;
    if (&req) begin
      gnt      = '0;
      gnt[ptr] = 1'b1;
    end
  end
endmodule

// File: rtl/cl2_csr_access_ctrl.sv
// Fixed-latency CSR read-modify-write sequencer: accept, READ, WRITE, RESP,
// with round-robin arbitration between core (port 0) and debug (port 1).
module cl2_csr_access_ctrl
  import cl2_csr_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  cl2_csr_access_ctrl_if.slave  bus
);
  csr_state_e           state;
  csr_req_t             req_q;
  logic [XLEN-1:0]      old_q;
  logic                 ill_q;
  logic                 we_q;
  logic [NUM_PORTS-1:0] gnt;
  logic                 gnt_id;
  logic                 acc;
  logic                 resp_hs;
  logic                 ill;
  logic [XLEN-1:0]      rmw_data;

  cl2_csr_rr_arb u_arb (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .req     (bus.req_valid_i),
    .gnt     (gnt),
    .adv     (resp_hs),
    .adv_id  (req_q.id)
  );

  assign bus.req_ready_o = (state == ST_IDLE) ? gnt : '0;
  assign acc             = |(bus.req_valid_i & bus.req_ready_o);
  assign gnt_id          = gnt[1];
  assign resp_hs         = (state == ST_RESP) && bus.resp_ready_i;
  assign ill             = csr_illegal(req_q.addr, req_q.op, req_q.wdata, req_q.priv);

  // Reset must kill an in-flight write in the very cycle it is asserted.
  assign bus.csr_we_o    = we_q & rst_n_i;

  always_comb begin
    case (req_q.op)
      CSR_RW:  rmw_data = req_q.wdata;
      CSR_RS:  rmw_data = bus.csr_rdata_i | req_q.wdata;
      CSR_RC:  rmw_data = bus.csr_rdata_i & ~req_q.wdata;
      default: rmw_data = bus.csr_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state            <= ST_IDLE;
      req_q            <= '0;
      old_q            <= '0;
      ill_q            <= 1'b0;
      we_q             <= 1'b0;
      bus.csr_addr_o   <= '0;
      bus.csr_wdata_o  <= '0;
      bus.resp_valid_o <= 1'b0;
      bus.resp_id_o    <= 1'b0;
      bus.resp_rdata_o <= '0;
      bus.resp_err_o   <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (state)
        ST_IDLE: if (acc) begin
          req_q.id       <= gnt_id;
          req_q.addr     <= bus.req_addr_i[gnt_id];
          req_q.op       <= csr_op_e'(bus.req_op_i[gnt_id]);
          req_q.wdata    <= bus.req_wdata_i[gnt_id];
          req_q.priv     <= bus.priv_i;
          bus.csr_addr_o <= bus.req_addr_i[gnt_id];
          state          <= ST_READ;
        end
        ST_READ: begin
          old_q           <= bus.csr_rdata_i;
          ill_q           <= ill;
          we_q            <= csr_op_writes(req_q.op, req_q.wdata) && !ill;
          bus.csr_wdata_o <= rmw_data;
          state           <= ST_WRITE;
        end
        ST_WRITE: begin
          bus.resp_valid_o <= 1'b1;
          bus.resp_id_o    <= req_q.id;
          bus.resp_rdata_o <= ill_q ? '0 : old_q;
          bus.resp_err_o   <= ill_q;
          state            <= ST_RESP;
        end
        ST_RESP: if (bus.resp_ready_i) begin
          bus.resp_valid_o <= 1'b0;
          state            <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cl2_csr_access_ctrl.sv
// Bench for cl2_csr_access_ctrl: behavioural CSR array, accept-time scoreboard
// of expected write/response per access, and directed scenario tasks.
module tb_cl2_csr_access_ctrl;
  import cl2_csr_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cl2_csr_access_ctrl_if bus();
  cl2_csr_access_ctrl dut (.clk_i(clk), .rst_n_i(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Behavioural field array: combinational read, write on csr_we_o.
  logic [XLEN-1:0]   mem [0:(1<<ADDR_W)-1];
  logic              pl_en = 1'b0;
  logic [ADDR_W-1:0] pl_addr = '0;
  logic [XLEN-1:0]   pl_data = '0;
  assign bus.csr_rdata_i = mem[bus.csr_addr_o];
  always @(posedge clk) begin
    if (bus.csr_we_o)  mem[bus.csr_addr_o] <= bus.csr_wdata_o;
    else if (pl_en)    mem[pl_addr] <= pl_data;
  end

  int unsigned cyc = 0;
  int unsigned we_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.csr_we_o) we_cnt <= we_cnt + 1;
  end

  typedef struct {
    int unsigned       cyc;
    logic              id;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [XLEN-1:0]   wdata;
    logic [XLEN-1:0]   rdata;
    logic              err;
  } exp_t;

  exp_t        q[$];
  logic        acc_log[$];
  logic        resp_log[$];
  int unsigned acc_cnt = 0;
  int unsigned resp_cnt = 0;
  bit          mon_en = 1'b0;
  logic            last_id;
  logic [XLEN-1:0] last_rdata;
  logic            last_err;

  always @(negedge clk) begin : mon_blk
    exp_t              e;
    logic [ADDR_W-1:0] a;
    logic [XLEN-1:0]   wd, old, nd;
    logic [1:0]        pr;
    csr_op_e           op;
    logic              wr, ill;
    if (mon_en && rst_n) begin
      if (q.size() != 0) begin
        e = q[0];
        checks++;
        if (bus.req_ready_o !== 2'b00) begin
          errors++; $display("FAIL ready_busy: got %b want 00", bus.req_ready_o);
        end
        checks++;
        if (cyc == e.cyc + 2) begin
          if (bus.csr_we_o !== e.we) begin
            errors++; $display("FAIL we_t2: got %b want %b", bus.csr_we_o, e.we);
          end else if (e.we && (bus.csr_addr_o !== e.addr || bus.csr_wdata_o !== e.wdata)) begin
            errors++; $display("FAIL wdata_t2: got %h@%h want %h@%h",
                               bus.csr_wdata_o, bus.csr_addr_o, e.wdata, e.addr);
          end
        end else if (bus.csr_we_o !== 1'b0) begin
          errors++; $display("FAIL we_outside_write: got 1 want 0 at cycle %0d", cyc);
        end
        checks++;
        if (bus.resp_valid_o !== (cyc >= e.cyc + 3)) begin
          errors++; $display("FAIL resp_valid_timing: got %b want %b (cycle T+%0d)",
                             bus.resp_valid_o, (cyc >= e.cyc + 3), cyc - e.cyc);
        end
        if (bus.resp_valid_o === 1'b1 && bus.resp_ready_i === 1'b1) begin
          checks++;
          if (bus.resp_id_o !== e.id || bus.resp_rdata_o !== e.rdata || bus.resp_err_o !== e.err) begin
            errors++; $display("FAIL resp: got id=%b rdata=%h err=%b want id=%b rdata=%h err=%b",
                               bus.resp_id_o, bus.resp_rdata_o, bus.resp_err_o, e.id, e.rdata, e.err);
          end
          last_id = bus.resp_id_o; last_rdata = bus.resp_rdata_o; last_err = bus.resp_err_o;
          resp_log.push_back(bus.resp_id_o);
          void'(q.pop_front());
          resp_cnt++;
        end
      end else begin
        checks++;
        if (bus.csr_we_o !== 1'b0 || bus.resp_valid_o !== 1'b0 || $countones(bus.req_ready_o) > 1) begin
          errors++; $display("FAIL idle_quiet: got we=%b resp_valid=%b ready=%b",
                             bus.csr_we_o, bus.resp_valid_o, bus.req_ready_o);
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
          if (bus.req_valid_i[p] && bus.req_ready_o[p]) begin
            a   = bus.req_addr_i[p];
            wd  = bus.req_wdata_i[p];
            op  = csr_op_e'(bus.req_op_i[p]);
            pr  = bus.priv_i;
            old = mem[a];
            wr  = (op == CSR_RW) || ((op == CSR_RS || op == CSR_RC) && wd != 0);
            ill = (a[9:8] > pr) || (a[11:10] == 2'b11 && wr);
            case (op)
              CSR_RW:  nd = wd;
              CSR_RS:  nd = old | wd;
              CSR_RC:  nd = old & ~wd;
              default: nd = old;
            endcase
            e.cyc = cyc; e.id = (p == 1); e.we = wr && !ill; e.addr = a;
            e.wdata = nd; e.rdata = ill ? '0 : old; e.err = ill;
            q.push_back(e);
            acc_log.push_back(p == 1);
            acc_cnt++;
          end
        end
      end
    end
  end

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [XLEN-1:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic do_access(input bit p, input logic [ADDR_W-1:0] a, input csr_op_e op,
                           input logic [XLEN-1:0] wd, input logic [1:0] pr);
    int unsigned rc0;
    bit got;
    rc0 = resp_cnt; got = 1'b0;
    bus.req_addr_i[p] = a; bus.req_op_i[p] = op; bus.req_wdata_i[p] = wd;
    bus.priv_i = pr; bus.req_valid_i[p] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req_ready_o[p]) begin got = 1'b1; break; end
    end
    @(posedge clk); #1;
    bus.req_valid_i[p] = 1'b0;
    for (int i = 0; i < 20 && resp_cnt == rc0; i++) @(posedge clk);
    #1;
    checks++;
    if (!got || resp_cnt == rc0) begin
      errors++; $display("FAIL access_timeout: accepted=%b responses=%0d want 1", got, resp_cnt - rc0);
    end
  endtask

  task automatic test_reset;
    mon_en = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.csr_we_o !== 1'b0 || bus.resp_valid_o !== 1'b0) begin
      errors++; $display("FAIL in_reset: got we=%b resp_valid=%b want 0 0", bus.csr_we_o, bus.resp_valid_o);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.resp_err_o !== 1'b0 || bus.resp_rdata_o !== '0 || bus.resp_id_o !== 1'b0 ||
        bus.csr_addr_o !== '0 || bus.csr_wdata_o !== '0 || bus.req_ready_o !== 2'b00) begin
      errors++; $display("FAIL reset_values: got err=%b rdata=%h id=%b addr=%h wdata=%h ready=%b want all 0",
                         bus.resp_err_o, bus.resp_rdata_o, bus.resp_id_o, bus.csr_addr_o,
                         bus.csr_wdata_o, bus.req_ready_o);
    end
    @(posedge clk); #1;
    bus.req_valid_i = 2'b11; #2;
    checks++;
    if (bus.req_ready_o !== 2'b01) begin
      errors++; $display("FAIL reset_ptr: got ready=%b want 01", bus.req_ready_o);
    end
    bus.req_valid_i = 2'b10; #1;
    checks++;
    if (bus.req_ready_o !== 2'b10) begin
      errors++; $display("FAIL single_req: got ready=%b want 10", bus.req_ready_o);
    end
    bus.req_valid_i = 2'b00;
    @(posedge clk); #1;
    mon_en = 1'b1;
  endtask

  task automatic test_core_rw;
    preload(12'h340, 32'h0000_1234);
    do_access(1'b0, 12'h340, CSR_RW, 32'hDEAD_BEEF, PRIV_M);
    checks++;
    if (last_id !== 1'b0 || last_rdata !== 32'h0000_1234 || last_err !== 1'b0 || mem[12'h340] !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL core_rw: got id=%b rdata=%h err=%b csr=%h want 0 00001234 0 deadbeef",
                         last_id, last_rdata, last_err, mem[12'h340]);
    end
  endtask

  task automatic test_rs_rc;
    int unsigned w0;
    preload(12'h342, 32'h0000_00F0);
    do_access(1'b1, 12'h342, CSR_RS, 32'h0000_000F, PRIV_M);
    checks++;
    if (mem[12'h342] !== 32'h0000_00FF || last_rdata !== 32'h0000_00F0) begin
      errors++; $display("FAIL rs: got csr=%h rdata=%h want 000000ff 000000f0", mem[12'h342], last_rdata);
    end
    preload(12'h342, 32'h0000_00F0);
    do_access(1'b0, 12'h342, CSR_RC, 32'h0000_0030, PRIV_M);
    checks++;
    if (mem[12'h342] !== 32'h0000_00C0 || last_rdata !== 32'h0000_00F0) begin
      errors++; $display("FAIL rc: got csr=%h rdata=%h want 000000c0 000000f0", mem[12'h342], last_rdata);
    end
    preload(12'h342, 32'h0000_00F0);
    w0 = we_cnt;
    do_access(1'b0, 12'h342, CSR_RS, 32'h0, PRIV_M);
    checks++;
    if (we_cnt != w0 || last_rdata !== 32'h0000_00F0 || last_err !== 1'b0) begin
      errors++; $display("FAIL rs_zero: got writes=%0d rdata=%h err=%b want 0 000000f0 0",
                         we_cnt - w0, last_rdata, last_err);
    end
  endtask

  task automatic test_illegal;
    int unsigned w0;
    preload(12'hF11, 32'h0000_5A5A);
    w0 = we_cnt;
    do_access(1'b0, 12'hF11, CSR_RW, 32'h0000_FFFF, PRIV_M);
    checks++;
    if (we_cnt != w0 || last_err !== 1'b1 || last_rdata !== '0 || mem[12'hF11] !== 32'h0000_5A5A) begin
      errors++; $display("FAIL ro_write: got writes=%0d err=%b rdata=%h csr=%h want 0 1 0 00005a5a",
                         we_cnt - w0, last_err, last_rdata, mem[12'hF11]);
    end
    preload(12'h300, 32'h0000_0077);
    do_access(1'b1, 12'h300, CSR_READ, 32'h0, PRIV_U);
    checks++;
    if (last_err !== 1'b1 || last_rdata !== '0 || last_id !== 1'b1) begin
      errors++; $display("FAIL priv_read: got err=%b rdata=%h id=%b want 1 0 1", last_err, last_rdata, last_id);
    end
  endtask

  // Drives n0/n1 back-to-back requests on each port, holding valid until done.
  task automatic run_stream(input int n0, input int n1);
    int rem[2];
    logic [1:0] acc;
    int unsigned rc0;
    rem[0] = n0; rem[1] = n1;
    rc0 = resp_cnt;
    bus.priv_i = PRIV_M;
    for (int p = 0; p < 2; p++) begin
      bus.req_addr_i[p] = (p == 0) ? 12'h340 : 12'h341;
      bus.req_op_i[p] = CSR_RW;
      bus.req_wdata_i[p] = (p == 0) ? 32'h100 : 32'h200;
      bus.req_valid_i[p] = (rem[p] > 0);
    end
    for (int c = 0; c < 200 && (rem[0] > 0 || rem[1] > 0); c++) begin
      @(negedge clk);
      acc = bus.req_valid_i & bus.req_ready_o;
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (acc[p]) begin
          rem[p]--;
          if (rem[p] == 0) bus.req_valid_i[p] = 1'b0;
          else bus.req_wdata_i[p] = bus.req_wdata_i[p] + 1;
        end
      end
    end
    bus.req_valid_i = 2'b00;
    for (int i = 0; i < 20 && resp_cnt != rc0 + n0 + n1; i++) @(posedge clk);
    #1;
    checks++;
    if (resp_cnt != rc0 + n0 + n1) begin
      errors++; $display("FAIL stream_timeout: got %0d responses want %0d", resp_cnt - rc0, n0 + n1);
    end
  endtask

  task automatic test_contention;
    logic exp_ids[4];
    exp_ids[0] = 1'b0; exp_ids[1] = 1'b1; exp_ids[2] = 1'b0; exp_ids[3] = 1'b1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    preload(12'h340, 32'h0);
    preload(12'h341, 32'h0);
    acc_log.delete(); resp_log.delete();
    run_stream(2, 2);
    checks++;
    if (acc_log.size() != 4 || resp_log.size() != 4) begin
      errors++; $display("FAIL contention_count: got %0d grants %0d responses want 4 4", acc_log.size(), resp_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (acc_log[i] !== exp_ids[i] || resp_log[i] !== exp_ids[i]) begin
          errors++; $display("FAIL contention_order[%0d]: got grant=%b id=%b want %b", i, acc_log[i], resp_log[i], exp_ids[i]);
        end
      end
    end
    acc_log.delete();
    run_stream(0, 2);
    checks++;
    if (acc_log.size() != 2 || acc_log[0] !== 1'b1 || acc_log[1] !== 1'b1) begin
      errors++; $display("FAIL port1_only: got %0d grants want 2 grants to port 1", acc_log.size());
    end
  endtask

  task automatic test_backpressure;
    logic [XLEN-1:0] rd;
    logic            id, er;
    int unsigned     a0, rc0;
    bit              got;
    preload(12'h340, 32'h0000_ABCD);
    preload(12'h341, 32'h0000_1111);
    bus.resp_ready_i = 1'b0;
    bus.priv_i = PRIV_M;
    bus.req_addr_i[0] = 12'h340; bus.req_op_i[0] = CSR_READ; bus.req_wdata_i[0] = '0;
    bus.req_addr_i[1] = 12'h341; bus.req_op_i[1] = CSR_READ; bus.req_wdata_i[1] = '0;
    bus.req_valid_i = 2'b01;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = bus.req_ready_o[0]; end
    @(posedge clk); #1;
    bus.req_valid_i = 2'b10;
    for (int i = 0; i < 20 && bus.resp_valid_o !== 1'b1; i++) @(negedge clk);
    rd = bus.resp_rdata_o; id = bus.resp_id_o; er = bus.resp_err_o;
    a0 = acc_cnt;
    checks++;
    if (!got || rd !== 32'h0000_ABCD || id !== 1'b0 || er !== 1'b0) begin
      errors++; $display("FAIL bp_resp: got accepted=%b rdata=%h id=%b err=%b want 1 0000abcd 0 0", got, rd, id, er);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.resp_valid_o !== 1'b1 || bus.resp_rdata_o !== rd || bus.resp_id_o !== id ||
          bus.resp_err_o !== er || bus.req_ready_o !== 2'b00) begin
        errors++; $display("FAIL bp_hold[%0d]: got valid=%b rdata=%h ready=%b want 1 %h 00",
                           i, bus.resp_valid_o, bus.resp_rdata_o, bus.req_ready_o, rd);
      end
    end
    checks++;
    if (acc_cnt != a0) begin
      errors++; $display("FAIL bp_no_accept: got %0d extra accepts want 0", acc_cnt - a0);
    end
    rc0 = resp_cnt;
    @(posedge clk); #1;
    bus.resp_ready_i = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = bus.req_ready_o[1]; end
    @(posedge clk); #1;
    bus.req_valid_i = 2'b00;
    for (int i = 0; i < 20 && resp_cnt != rc0 + 2; i++) @(posedge clk);
    #1;
    checks++;
    if (!got || resp_cnt != rc0 + 2 || last_id !== 1'b1 || last_rdata !== 32'h0000_1111) begin
      errors++; $display("FAIL bp_followup: got accepted=%b responses=%0d id=%b rdata=%h want 1 2 1 00001111",
                         got, resp_cnt - rc0, last_id, last_rdata);
    end
  endtask

  task automatic test_reset_in_write;
    bit got;
    preload(12'h340, 32'h0000_1111);
    mon_en = 1'b0;
    bus.priv_i = PRIV_M;
    bus.req_addr_i[0] = 12'h340; bus.req_op_i[0] = CSR_RW; bus.req_wdata_i[0] = 32'hAAAA_5555;
    bus.req_valid_i = 2'b01;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = bus.req_ready_o[0]; end
    @(posedge clk); #1;
    bus.req_valid_i = 2'b00;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (!got || bus.csr_we_o !== 1'b0) begin
      errors++; $display("FAIL rst_write_we: got accepted=%b we=%b want 1 0", got, bus.csr_we_o);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.resp_valid_o !== 1'b0 || bus.resp_err_o !== 1'b0 || bus.resp_rdata_o !== '0 ||
        bus.resp_id_o !== 1'b0 || bus.csr_addr_o !== '0 || bus.csr_wdata_o !== '0 ||
        bus.csr_we_o !== 1'b0 || bus.req_ready_o !== 2'b00) begin
      errors++; $display("FAIL rst_write_outputs: got valid=%b err=%b rdata=%h addr=%h wdata=%h we=%b want all 0",
                         bus.resp_valid_o, bus.resp_err_o, bus.resp_rdata_o, bus.csr_addr_o,
                         bus.csr_wdata_o, bus.csr_we_o);
    end
    checks++;
    if (mem[12'h340] !== 32'h0000_1111) begin
      errors++; $display("FAIL rst_write_csr: got %h want 00001111", mem[12'h340]);
    end
    @(posedge clk); #1;
    bus.req_valid_i = 2'b01; #2;
    checks++;
    if (bus.req_ready_o !== 2'b01 || bus.resp_valid_o !== 1'b0) begin
      errors++; $display("FAIL rst_write_idle: got ready=%b resp_valid=%b want 01 0", bus.req_ready_o, bus.resp_valid_o);
    end
    bus.req_valid_i = 2'b00;
    q.delete();
    @(posedge clk); #1;
    mon_en = 1'b1;
  endtask

  initial begin
    bus.req_valid_i = '0; bus.req_addr_i = '0; bus.req_op_i = '0; bus.req_wdata_i = '0;
    bus.priv_i = PRIV_M; bus.resp_ready_i = 1'b1;
    last_id = 1'b0; last_rdata = '0; last_err = 1'b0;
    test_reset();
    test_core_rw();
    test_rs_rc();
    test_illegal();
    test_contention();
    test_backpressure();
    test_reset_in_write();
    test_core_rw();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cl2_csr_access_ctrl.md
# cl2_csr_access_ctrl

Sequencer and arbiter in front of the CSR register file, which is built from `cl2_csr_field` instances. It accepts CSR access requests from two requesters, the core pipeline (port 0) and the debug module (port 1), and serves them one at a time with round-robin arbitration. Each access is a fixed-latency read-modify-write: read the CSR, check privilege and read-only rules, compute the new value, then drive a single-cycle write enable into the field array. One response channel returns read data and an error flag, tagged with the requester id.

## Interface
- `XLEN`, 32: CSR data width.
- `ADDR_W`, 12: CSR address width.
- `clk_i` in 1: clock.
- `rst_n_i` in 1: reset. One clock; reset is synchronous and active-low.
- `req_valid_i` in 2: per-port request valid (bit0 core, bit1 debug).
- `req_ready_o` out 2: per-port accept.
- `req_addr_i` in 2×ADDR_W: per-port CSR address.
- `req_op_i` in 2×2: per-port op, encoded `csr_op_e`: READ=0, RW=1, RS=2, RC=3.
- `req_wdata_i` in 2×XLEN: per-port operand.
- `priv_i` in 2: current privilege (0 U, 1 S, 3 M). Sampled at accept.
- `csr_addr_o` out ADDR_W: address to the field array.
- `csr_rdata_i` in XLEN: combinational read data for `csr_addr_o`.
- `csr_we_o` out 1: write enable, fans out to the field `wr_en_i` of the decoded CSR.
- `csr_wdata_o` out XLEN: write data.
- `resp_valid_o` out 1: response valid.
- `resp_ready_i` in 1: response accept.
- `resp_id_o` out 1: requester id.
- `resp_rdata_o` out XLEN: old CSR value, or 0 on error.
- `resp_err_o` out 1: illegal access.

## Operation
- FSM states: IDLE, READ, WRITE, RESP.
- **IDLE**
  - `req_ready_o` is nonzero only in IDLE, and at most one bit is set, driven combinationally from the arbiter grant.
  - On a handshake, latch port id, addr, op, wdata and priv, then go to READ.
- **Arbitration**
  - Round-robin over the 2 ports.
  - The priority pointer points to the port after the last granted one. Reset value: port 0 has priority.
  - With a single requester, that requester is granted regardless of the pointer.
- **READ**
  - `csr_addr_o` = latched addr. Capture `csr_rdata_i` into the old-value register.
  - Compute illegal = (addr[9:8] > priv) OR (addr[11:10]==2'b11 AND op writes).
  - "Op writes" means RW, or RS/RC with wdata ≠ 0. READ never writes.
  - Go to WRITE.
- **WRITE**
  - `csr_addr_o` is still the latched addr.
  - `csr_we_o` = op writes AND !illegal.
  - `csr_wdata_o` by op: RW gives wdata; RS gives old | wdata; RC gives old & ~wdata.
  - Go to RESP. Illegal accesses also pass through WRITE, with the write suppressed, so latency stays fixed.
- **RESP**
  - `resp_valid_o`=1 and held stable until `resp_ready_i`.
  - `resp_rdata_o` = old value, or 0 if illegal.
  - On handshake, advance the arbiter pointer past the served port and return to IDLE.
- **Reset mid-operation**: the next state is IDLE, and `csr_we_o` is 0 in any cycle where `rst_n_i`=0, even from WRITE. No response is issued for the aborted access.

## Timing
- Reset values:
  - state IDLE, `csr_we_o` 0, `resp_valid_o` 0, `resp_err_o` 0.
  - `resp_rdata_o` 0, `resp_id_o` 0, `csr_addr_o` 0, `csr_wdata_o` 0.
  - Arbiter pointer at port 0.
- Cycle numbering, with accept at cycle T:
  - T+1: READ.
  - T+2: WRITE, with `csr_we_o` high for exactly 1 cycle. The field register updates at the edge ending T+2.
  - T+3: `resp_valid_o` rises.
- Next accept is possible in the cycle after the response handshake. Maximum throughput is one access per 4 cycles.
- `csr_we_o` never asserts outside WRITE and never for 2 consecutive cycles.
- Requests not accepted must be held stable by the requester. The block never drops a valid request.

## Structure
- Package `cl2_csr_pkg` holds:
  - `csr_op_e`, the FSM state enum, `XLEN`, `ADDR_W`.
  - Privilege-level constants.
  - Address-field helpers for the read-only bits [11:10] and the privilege bits [9:8].
- Sub-module `cl2_csr_rr_arb`: 2-requester round-robin arbiter with grant and pointer-advance inputs.
- The FSM, legality check and RMW datapath live in the top module.

## Test plan
1. **Core RW, M-mode**: port0 RW addr 0x340, wdata 0xDEAD_BEEF, old value 0x1234.
   - `csr_we_o` high at T+2 with `csr_wdata_o` 0xDEAD_BEEF.
   - At T+3: rdata 0x1234, err 0, id 0.
2. **RS and RC**: with old value 0x00F0.
   - RS 0x000F writes 0x00FF.
   - RC 0x0030 writes 0x00C0.
   - RS with wdata 0 writes nothing (`csr_we_o` stays 0) and returns 0x00F0.
3. **Illegal accesses**:
   - RW to read-only addr 0xF11 gives no write, err 1, rdata 0.
   - READ at U-mode to M-only addr 0x300 gives err 1.
   - Latency is still 3 cycles in both cases.
4. **Contention**: both ports valid continuously for 4 accesses.
   - Grants alternate 0,1,0,1 and `resp_id_o` matches.
   - With only port1 valid, port1 is granted every time.
5. **Backpressure**: `resp_ready_i` low for 5 cycles.
   - The response is held stable and `req_ready_o` stays 0.
   - No second accept until the response handshake.
6. **Reset in WRITE**: assert `rst_n_i` during the WRITE cycle.
   - `csr_we_o` stays 0 and the CSR is unchanged.
   - Next cycle is IDLE with all outputs at reset values.
